id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register directly downstream of the ID-stage register-read forwarding logic.
- Captures the forwarded operands and decoded control each cycle and presents them to EX.
- Detects load-use hazards: a load in EX whose data cannot be forwarded yet. On a hazard it stalls ID for one cycle and inserts a bubble.
- Also handles downstream stall (hold) and branch/exception flush.

---
 rtl/id_ex_pipe_reg.sv | 155 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble insertion, hold and flush
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int ALUOP_W = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [DATA_W-1:0]  id_pc,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic               id_read_en_1,
   input  logic               id_read_en_2,
   input  logic [ADDR_W-1:0]  id_read_addr_1,
   input  logic [ADDR_W-1:0]  id_read_addr_2,
   input  logic [DATA_W-1:0]  id_operand_1,
   input  logic [DATA_W-1:0]  id_operand_2,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic               id_wreg_en,
   input  logic [ADDR_W-1:0]  id_wreg_addr,
   input  logic               id_is_load,
   input  logic               flush,
   input  logic               ex_stall,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_pc,
   output logic [ALUOP_W-1:0] ex_aluop,
   output logic [DATA_W-1:0]  ex_operand_1,
   output logic [DATA_W-1:0]  ex_operand_2,
   output logic [DATA_W-1:0]  ex_imm,
   output logic               ex_wreg_en,
   output logic [ADDR_W-1:0]  ex_wreg_addr,
   output logic               ex_is_load,
   output logic               id_stall_req,
   output logic [CNT_W-1:0]   bubble_cnt
);

   logic               valid_q,   valid_d;
   logic [DATA_W-1:0]  pc_q,      pc_d;
   logic [ALUOP_W-1:0] aluop_q,   aluop_d;
   logic [DATA_W-1:0]  op1_q,     op1_d;
   logic [DATA_W-1:0]  op2_q,     op2_d;
   logic [DATA_W-1:0]  imm_q,     imm_d;
   logic               wen_q,     wen_d;
   logic [ADDR_W-1:0]  waddr_q,   waddr_d;
   logic               is_load_q, is_load_d;

   logic load_use;
   logic bubble_ins;

   // A load in EX whose result ID needs cannot be forwarded until it reaches MEM.
   always_comb begin
      load_use = valid_q && is_load_q && wen_q && (waddr_q != '0) && id_valid &&
                 ((id_read_en_1 && (id_read_addr_1 == waddr_q)) ||
                  (id_read_en_2 && (id_read_addr_2 == waddr_q)));
   end

   assign id_stall_req = (ex_stall || load_use) && !flush;
   assign bubble_ins   = !flush && !ex_stall && load_use;

   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      aluop_d   = aluop_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      imm_d     = imm_q;
      wen_d     = wen_q;
      waddr_d   = waddr_q;
      is_load_d = is_load_q;
      if (flush || (!ex_stall && load_use)) begin
         valid_d   = 1'b0;
         pc_d      = '0;
         aluop_d   = '0;
         op1_d     = '0;
         op2_d     = '0;
         imm_d     = '0;
         wen_d     = 1'b0;
         waddr_d   = '0;
         is_load_d = 1'b0;
      end else if (!ex_stall) begin
         valid_d   = id_valid;
         pc_d      = id_pc;
         aluop_d   = id_aluop;
         op1_d     = id_operand_1;
         op2_d     = id_operand_2;
         imm_d     = id_imm;
         // Invalid slots must never look like a writer to the forwarding logic.
         wen_d     = id_wreg_en && id_valid;
         waddr_d   = id_wreg_addr;
         is_load_d = id_is_load && id_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         aluop_q   <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         imm_q     <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         is_load_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         aluop_q   <= aluop_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         imm_q     <= imm_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         is_load_q <= is_load_d;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (bubble_ins && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bubble_cnt = cnt_q;
`else
   logic unused_bubble;
   assign unused_bubble = bubble_ins;
   assign bubble_cnt    = '0;
`endif

   assign ex_valid     = valid_q;
   assign ex_pc        = pc_q;
   assign ex_aluop     = aluop_q;
   assign ex_operand_1 = op1_q;
   assign ex_operand_2 = op2_q;
   assign ex_imm       = imm_q;
   assign ex_wreg_en   = wen_q;
   assign ex_wreg_addr = waddr_q;
   assign ex_is_load   = is_load_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [7:0]  id_aluop;
   logic        id_read_en_1, id_read_en_2;
   logic [4:0]  id_read_addr_1, id_read_addr_2;
   logic [31:0] id_operand_1, id_operand_2, id_imm;
   logic        id_wreg_en;
   logic [4:0]  id_wreg_addr;
   logic        id_is_load;
   logic        flush, ex_stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [7:0]  ex_aluop;
   logic [31:0] ex_operand_1, ex_operand_2, ex_imm;
   logic        ex_wreg_en;
   logic [4:0]  ex_wreg_addr;
   logic        ex_is_load;
   logic        id_stall_req;
   logic [15:0] bubble_cnt;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [7:0]  aluop;
      logic [31:0] op1, op2, imm;
      logic        wen;
      logic [4:0]  waddr;
      logic        isload;
      logic [15:0] cnt;
   } exp_t;

   exp_t m;
   exp_t sb[$];
   logic [15:0] saved_cnt;

   always #5 clk = ~clk;

   id_ex_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_aluop(id_aluop),
      .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
      .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
      .id_operand_1(id_operand_1), .id_operand_2(id_operand_2), .id_imm(id_imm),
      .id_wreg_en(id_wreg_en), .id_wreg_addr(id_wreg_addr), .id_is_load(id_is_load),
      .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_aluop(ex_aluop), .ex_operand_1(ex_operand_1), .ex_operand_2(ex_operand_2),
      .ex_imm(ex_imm), .ex_wreg_en(ex_wreg_en), .ex_wreg_addr(ex_wreg_addr),
      .ex_is_load(ex_is_load), .id_stall_req(id_stall_req), .bubble_cnt(bubble_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t bubble(input exp_t s);
      exp_t b;
      b = '{valid: 1'b0, pc: '0, aluop: '0, op1: '0, op2: '0, imm: '0,
            wen: 1'b0, waddr: '0, isload: 1'b0, cnt: s.cnt};
      return b;
   endfunction

   task automatic step();
      logic lu, stall_exp;
      exp_t n, e;
      #1;
      lu = m.valid && m.isload && m.wen && (m.waddr != 5'd0) && id_valid &&
           ((id_read_en_1 && id_read_addr_1 == m.waddr) || (id_read_en_2 && id_read_addr_2 == m.waddr));
      stall_exp = (ex_stall || lu) && !flush;
      check("id_stall_req", 64'(id_stall_req), 64'(stall_exp));
      if (!rst_n) begin
         n = bubble(m);
         n.cnt = '0;
      end else if (flush) begin
         n = bubble(m);
      end else if (ex_stall) begin
         n = m;
      end else if (lu) begin
         n = bubble(m);
         if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
      end else begin
         n = '{valid: id_valid, pc: id_pc, aluop: id_aluop, op1: id_operand_1,
               op2: id_operand_2, imm: id_imm, wen: id_wreg_en && id_valid,
               waddr: id_wreg_addr, isload: id_is_load && id_valid, cnt: m.cnt};
      end
      sb.push_back(n);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("ex_valid", 64'(ex_valid), 64'(e.valid));
      check("ex_pc", 64'(ex_pc), 64'(e.pc));
      check("ex_aluop", 64'(ex_aluop), 64'(e.aluop));
      check("ex_operand_1", 64'(ex_operand_1), 64'(e.op1));
      check("ex_operand_2", 64'(ex_operand_2), 64'(e.op2));
      check("ex_imm", 64'(ex_imm), 64'(e.imm));
      check("ex_wreg_en", 64'(ex_wreg_en), 64'(e.wen));
      check("ex_wreg_addr", 64'(ex_wreg_addr), 64'(e.waddr));
      check("ex_is_load", 64'(ex_is_load), 64'(e.isload));
`ifdef ID_EX_PERF_CNT_EN
      check("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
`else
      check("bubble_cnt", 64'(bubble_cnt), 64'(0));
`endif
      m = e;
   endtask

   task automatic drive_load(input logic [31:0] pc, input logic [4:0] rd);
      id_valid = 1'b1; id_pc = pc; id_is_load = 1'b1; id_wreg_en = 1'b1; id_wreg_addr = rd;
      id_read_en_1 = 1'b0; id_read_en_2 = 1'b0; id_read_addr_1 = 5'd0; id_read_addr_2 = 5'd0;
   endtask

   task automatic drive_user(input logic [31:0] pc, input logic en1, input logic [4:0] a1,
                             input logic en2, input logic [4:0] a2);
      id_valid = 1'b1; id_pc = pc; id_is_load = 1'b0; id_wreg_en = 1'b1; id_wreg_addr = 5'd6;
      id_read_en_1 = en1; id_read_addr_1 = a1; id_read_en_2 = en2; id_read_addr_2 = a2;
      id_operand_1 = pc ^ 32'h5A5A_0000; id_operand_2 = pc + 32'd7; id_imm = 32'h0000_0010;
      id_aluop = pc[7:0];
   endtask

   initial begin
      m = '{valid: 1'b0, pc: '0, aluop: '0, op1: '0, op2: '0, imm: '0,
            wen: 1'b0, waddr: '0, isload: 1'b0, cnt: '0};
      rst_n = 1'b0; id_valid = 1'b1; id_pc = 32'h100; id_aluop = 8'h11;
      id_read_en_1 = 1'b0; id_read_en_2 = 1'b0; id_read_addr_1 = '0; id_read_addr_2 = '0;
      id_operand_1 = '0; id_operand_2 = '0; id_imm = '0;
      id_wreg_en = 1'b0; id_wreg_addr = '0; id_is_load = 1'b0; flush = 1'b0; ex_stall = 1'b0;

      // reset held for two cycles with live ID inputs
      step();
      step();
      check("rst_ex_valid", 64'(ex_valid), 64'(0));
      check("rst_ex_pc", 64'(ex_pc), 64'(0));
      check("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
      rst_n = 1'b1;
      step();
      check("first_ex_pc", 64'(ex_pc), 64'h100);
      check("first_ex_valid", 64'(ex_valid), 64'(1));

      // normal flow
      id_pc = 32'h104; id_operand_1 = 32'hDEADBEEF; id_wreg_addr = 5'd3; id_wreg_en = 1'b1;
      step();
      check("norm_op1", 64'(ex_operand_1), 64'hDEADBEEF);
      check("norm_waddr", 64'(ex_wreg_addr), 64'(3));
      check("norm_wen", 64'(ex_wreg_en), 64'(1));

      // load-use on source 2
      drive_load(32'h1F0, 5'd5);
      step();
      drive_user(32'h200, 1'b0, 5'd9, 1'b1, 5'd5);
      #1 check("lu_stall_req", 64'(id_stall_req), 64'(1));
      step();
      check("lu_bubble_valid", 64'(ex_valid), 64'(0));
      check("lu_bubble_wen", 64'(ex_wreg_en), 64'(0));
      step();
      check("lu_capture_pc", 64'(ex_pc), 64'h200);
      check("lu_capture_valid", 64'(ex_valid), 64'(1));
`ifdef ID_EX_PERF_CNT_EN
      check("lu_bubble_cnt", 64'(bubble_cnt), 64'(1));
`endif

      // exclusions: destination r0, and source not enabled
      drive_load(32'h300, 5'd0);
      step();
      drive_user(32'h304, 1'b0, 5'd0, 1'b1, 5'd0);
      step();
      check("excl_r0_valid", 64'(ex_valid), 64'(1));
      drive_load(32'h308, 5'd5);
      step();
      drive_user(32'h30C, 1'b0, 5'd0, 1'b0, 5'd5);
      step();
      check("excl_en_valid", 64'(ex_valid), 64'(1));

      // downstream stall while a hazard is pending
      drive_load(32'h400, 5'd5);
      step();
      drive_user(32'h404, 1'b1, 5'd5, 1'b0, 5'd0);
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold_pc", 64'(ex_pc), 64'h400);
      end
      ex_stall = 1'b0;
      step();
      check("stall_rel_bubble", 64'(ex_valid), 64'(0));
      step();
      check("stall_rel_capture", 64'(ex_pc), 64'h404);

      // flush beats stall and hazard
      drive_load(32'h500, 5'd5);
      step();
      saved_cnt = bubble_cnt;
      drive_user(32'h504, 1'b1, 5'd5, 1'b1, 5'd5);
      flush = 1'b1; ex_stall = 1'b1;
      #1 check("flush_stall_req", 64'(id_stall_req), 64'(0));
      step();
      check("flush_valid", 64'(ex_valid), 64'(0));
      check("flush_cnt", 64'(bubble_cnt), 64'(saved_cnt));
      flush = 1'b0; ex_stall = 1'b0;

      // invalid slot never advertises a write or load
      drive_load(32'h600, 5'd7);
      id_valid = 1'b0;
      step();
      check("inv_wen", 64'(ex_wreg_en), 64'(0));
      check("inv_load", 64'(ex_is_load), 64'(0));

      // reset overrides a stall
      id_valid = 1'b1; id_is_load = 1'b0;
      step();
      ex_stall = 1'b1; rst_n = 1'b0;
      step();
      check("rst_stall_valid", 64'(ex_valid), 64'(0));
      rst_n = 1'b1; ex_stall = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
